regfile_wb_queue: RTL
=====================

Name: regfile_wb_queue

Overview:
- Writeback-side writer for the three-ported register file. It accepts register-write requests from two producers, the ALU result path and the memory load path, over valid/ready handshakes.
- Requests are buffered in an in-order queue, then drained one per cycle onto the register file's single write port (regWrite/writeAddr3/writeData3).
- Combinational forwarding lookups let the decode stage see values that are still queued but not yet written.
- Sits between the execute/memory stages and the register file.

Parameters:
n, 16, data width of a register
r, 3, register address width
DEPTH, 4, queue entries; power of two, >= 2

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
alu_valid  input  1  ALU write request valid
alu_ready  output  1  ALU request accepted this cycle when alu_valid & alu_ready
alu_addr  input  r  ALU destination register
alu_data  input  n  ALU result
mem_valid  input  1  load write request valid
mem_ready  output  1  load request accepted this cycle when mem_valid & mem_ready
mem_addr  input  r  load destination register
mem_data  input  n  load data
wr_hold  input  1  when 1, the write port is unavailable and no drain occurs
regWrite  output  1  register file write enable
writeAddr3  output  r  register file write address
writeData3  output  n  register file write data
fwd_addr1  input  r  forwarding lookup address, port 1
fwd_addr2  input  r  forwarding lookup address, port 2
fwd_hit1  output  1  a queued write to fwd_addr1 exists
fwd_data1  output  n  data of the youngest queued write to fwd_addr1
fwd_hit2  output  1  same as fwd_hit1, for port 2
fwd_data2  output  n  same as fwd_data1, for port 2
pending_count  output  $clog2(DEPTH+1)  number of queued entries
full  output  1  pending_count == DEPTH
empty  output  1  pending_count == 0

Behaviour:
- Reset (synchronous, active-high, sampled on posedge clock):
  - Pointers and count go to 0; all queued entries are discarded, including mid-drain.
  - In the cycle after reset: regWrite=0, empty=1, full=0, fwd_hit1/2=0.
  - While reset=1, both ready outputs are 0.
- Acceptance:
  - At most one enqueue per cycle; mem has fixed priority over alu, because loads are older.
  - mem_ready = !full.
  - alu_ready = !full & !mem_valid.
  - Readies depend only on registered state and mem_valid; they never depend on whether a dequeue happens in the same cycle. A full queue therefore refuses input even while draining.
- Address 0 (hardwired zero register):
  - A handshake with addr==0 completes normally (ready obeys the rules above) but the request is not enqueued.
- Drain:
  - regWrite = !empty & !wr_hold, combinational from registered state plus wr_hold.
  - writeAddr3/writeData3 = head entry whenever !empty; 0 when empty.
  - On a cycle with regWrite=1, the head is popped at the clock edge. The register file captures it on that same edge.
- Latency: a request accepted at edge k appears on the write port in cycle k+1 at the earliest (queue empty, no hold). It is written at edge k+1.
- Simultaneous enqueue and dequeue: count is unchanged, and the new entry goes to the tail.
- Pointers wrap modulo DEPTH.
- Forwarding (combinational over valid queued entries):
  - The search covers the entries currently in the queue. A request being accepted this cycle is not visible.
  - Youngest match wins.
  - fwd_addr==0 never hits, and fwd_data=0 when there is no hit.
  - An entry being written this cycle still reports a hit.
- Ordering: entries drain strictly in acceptance order, so two writes to the same register land oldest-first.

Test Plan:
- Reset and single write: reset 1 cycle, then alu_valid with addr=3, data=16'h00AB -> alu_ready=1; next cycle regWrite=1, writeAddr3=3, writeData3=16'h00AB, fwd_addr1=3 gives fwd_hit1=1; following cycle empty=1.
- Priority: mem_valid and alu_valid both high, mem addr=2 data=16'h1111, alu addr=5 data=16'h2222 -> mem accepted with alu_ready=0; alu accepted the next cycle; writes appear as addr 2 then addr 5.
- Hold and full: wr_hold=1 and 4 alu writes to addr 1..4 -> full=1, pending_count=4, 5th request sees alu_ready=0; release hold -> writes 1,2,3,4 on 4 consecutive cycles; simultaneous enqueue+dequeue keeps count steady.
- Forwarding youngest: with hold=1, enqueue addr 6 data 16'h0001, then addr 6 data 16'h0002 -> fwd_addr2=6 gives fwd_hit2=1, fwd_data2=16'h0002; fwd_addr1=0 gives fwd_hit1=0.
- Zero register: alu write with addr=0 -> alu_ready=1 but pending_count stays 0 and regWrite stays 0.
- Reset mid-operation: 3 entries queued under hold, assert reset -> next cycle pending_count=0, regWrite=0, no queued write ever appears afterwards.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// Writeback queue for the register file: merges ALU and load write requests into an
// in-order FIFO, drains one entry per cycle to the write port, and forwards queued values.
`timescale 1ns/1ps

module regfile_wb_queue #(
    parameter int n     = 16,
    parameter int r     = 3,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [r-1:0]                 alu_addr,
    input  logic [n-1:0]                 alu_data,
    input  logic                         mem_valid,
    output logic                         mem_ready,
    input  logic [r-1:0]                 mem_addr,
    input  logic [n-1:0]                 mem_data,
    input  logic                         wr_hold,
    output logic                         regWrite,
    output logic [r-1:0]                 writeAddr3,
    output logic [n-1:0]                 writeData3,
    input  logic [r-1:0]                 fwd_addr1,
    input  logic [r-1:0]                 fwd_addr2,
    output logic                         fwd_hit1,
    output logic [n-1:0]                 fwd_data1,
    output logic                         fwd_hit2,
    output logic [n-1:0]                 fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0]   pending_count,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [r-1:0]  r_addr [DEPTH];
    logic [n-1:0]  r_data [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_accMem;
    logic          w_accAlu;
    logic          w_enq;
    logic          w_deq;
    logic [r-1:0]  w_enqAddr;
    logic [n-1:0]  w_enqData;
    logic [PW-1:0] w_idx;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Loads are older than ALU results, so mem always wins the single enqueue slot.
    assign mem_ready = !reset && !w_full;
    assign alu_ready = !reset && !w_full && !mem_valid;

    assign w_accMem  = mem_valid && mem_ready;
    assign w_accAlu  = alu_valid && alu_ready;
    assign w_enqAddr = w_accMem ? mem_addr : alu_addr;
    assign w_enqData = w_accMem ? mem_data : alu_data;
    assign w_enq     = (w_accMem || w_accAlu) && (w_enqAddr != '0);
    assign w_deq     = regWrite;

    assign regWrite      = !w_empty && !wr_hold;
    assign writeAddr3    = w_empty ? '0 : r_addr[r_head];
    assign writeData3    = w_empty ? '0 : r_data[r_head];
    assign pending_count = r_count;
    assign full          = w_full;
    assign empty         = w_empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + 1'b1;
            if (w_deq) r_head <= r_head + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_enq) begin
            r_addr[r_tail] <= w_enqAddr;
            r_data[r_tail] <= w_enqData;
        end
    end

    // Walk oldest to youngest so a later match overwrites an earlier one.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        w_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (CW'(i) < r_count) begin
                if (fwd_addr1 != '0 && r_addr[w_idx] == fwd_addr1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = r_data[w_idx];
                end
                if (fwd_addr2 != '0 && r_addr[w_idx] == fwd_addr2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = r_data[w_idx];
                end
            end
        end
    end
endmodule
